country_car_detector: RTL
=========================

Name: country_car_detector

Overview:
- Upstream stage of the highway/country traffic-light controller; produces its X (car-waiting) input.
- Conditions the raw country-road loop sensor: synchronise, debounce, count queued cars, and track departures while the country light is GREEN.
- Asserts X when enough cars queue or one waits too long; drops X when the queue empties.

Parameters:
- DEBOUNCE, 4, cycles synchronised sensor must hold a new level before it is accepted (>=1).
- CNT_W, 4, width of car counter.
- MAX_CARS, 15, saturation value of car counter (<= 2^CNT_W-1).
- THRESHOLD, 3, queue length that raises X immediately (1..MAX_CARS).
- MAX_WAIT, 20, cycles a non-empty, below-threshold queue waits before X is raised.
- DEPART_CYCLES, 5, cycles of country GREEN per departing car.

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  asynchronous active-high reset.
- car_raw  input  1  raw loop sensor, asynchronous, 1 = vehicle present.
- country  input  2  country light from controller: 0 RED, 1 YELLOW, 2 GREEN.
- X  output  1  car-waiting request to controller.
- car_count  output  CNT_W  current queued-car count.
- arrival  output  1  one-cycle pulse per accepted car arrival.

Behaviour:
- Reset (clear=1, async): synchroniser flops, debounced level, all counters, FSM -> 0/IDLE; X=0, car_count=0, arrival=0. Reset mid-operation discards queue and timers; first valid arrival after release counts normally.
- Synchroniser: 2 flops on car_raw; debounce counter compares sync output to debounced level db; counter resets on mismatch-change, db updates after DEBOUNCE consecutive differing cycles.
- Arrival: rising edge of db -> arrival=1 for exactly one cycle (registered); latency raw->arrival = 2 + DEBOUNCE + 1 cycles. Falling edge ignored.
- Departure: when country==2, depart timer counts 1..DEPART_CYCLES; at DEPART_CYCLES with car_count>0, one car departs, timer restarts. Timer clears whenever country!=2.
- Counter: +1 on arrival, -1 on departure, unchanged if both same cycle. Saturates at MAX_CARS (arrival ignored, arrival pulse still issued); never below 0.
- FSM (X registered, Moore):
  - IDLE: X=0, wait timer 0. car_count becomes >0 -> WAIT (or REQ if >=THRESHOLD).
  - WAIT: X=0, wait timer increments. count>=THRESHOLD or timer==MAX_WAIT-1 -> REQ; count==0 -> IDLE.
  - REQ: X=1. country==2 -> SERVE; count==0 -> IDLE.
  - SERVE: X=1 while count>0. count==0 -> IDLE (X=0 next cycle). country leaves GREEN with count>0 -> REQ.
- X changes only on clk; combinational path from car_raw or country to X is forbidden.
- Encodings of country 3 treated as RED.

Optional Feature:
- Macro MIN_GREEN_HOLD_EN. Defined: adds parameter MIN_GREEN (default 8); in SERVE, X held 1 for at least MIN_GREEN cycles after country first reads GREEN even if count hits 0; exit to IDLE after hold expires with count==0. Undefined: no hold, X drops on count==0 as above.

Test Plan:
- Reset: clear pulsed mid-queue with car_count=2, X=1 -> X=0, car_count=0 immediately (async), IDLE after release.
- Glitch: car_raw high 3 cycles then low -> no arrival, car_count stays 0; held 10 cycles -> one arrival pulse 7 cycles after rise, car_count=1.
- Threshold: three clean arrivals, country=0 -> X=1 the cycle after car_count reaches 3.
- Wait timeout: one arrival, country=0 -> X rises exactly MAX_WAIT=20 cycles after entering WAIT.
- Service: car_count=3, country=2 held -> decrements every 5 cycles, reaches 0 at cycle 15, X=0 next cycle; arrival coinciding with departure leaves count unchanged.
- Saturation: 17 arrivals -> car_count=15, 17 arrival pulses, no wrap.

Source files
------------

// File: rtl/country_car_detector.sv
// Country-road car detector: sync + debounce loop sensor, count queue, raise X.
// Ports: clk, clear (async, active high), car_raw, country[1:0] -> X, car_count, arrival.
// Optional MIN_GREEN_HOLD_EN: holds X in SERVE for MIN_GREEN cycles after green.
module country_car_detector #(
  parameter int DEBOUNCE      = 4,
  parameter int CNT_W         = 4,
  parameter int MAX_CARS      = 15,
  parameter int THRESHOLD     = 3,
  parameter int MAX_WAIT      = 20,
  parameter int DEPART_CYCLES = 5
`ifdef MIN_GREEN_HOLD_EN
  ,
  parameter int MIN_GREEN     = 8
`endif
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             car_raw,
  input  logic [1:0]       country,
  output logic             X,
  output logic [CNT_W-1:0] car_count,
  output logic             arrival
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int WT_W = $clog2(MAX_WAIT + 1);
  localparam int DP_W = $clog2(DEPART_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REQ,
    SERVE
  } state_t;

  state_t state, nxt;

  logic            s1, s2;
  logic            db, db_q;
  logic [DB_W-1:0] dbcnt;
  logic [WT_W-1:0] wtmr;
  logic [DP_W-1:0] dtmr;
  logic            green;
  logic            dep;
  logic            empty;
  logic            full;
  logic            over;

  // Encoding 3 is not GREEN, so it behaves as RED.
  assign green = (country == 2'd2);
  assign empty = (car_count == '0);
  assign full  = (car_count == CNT_W'(MAX_CARS));
  assign over  = (car_count >= CNT_W'(THRESHOLD));
  assign dep   = green && !empty
              && (dtmr == DP_W'(DEPART_CYCLES - 1));

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      db    <= 1'b0;
      db_q  <= 1'b0;
      dbcnt <= '0;
    end else begin
      s1   <= car_raw;
      s2   <= s1;
      db_q <= db;
      if (s2 != db) begin
        if (dbcnt == DB_W'(DEBOUNCE - 1)) begin
          db    <= s2;
          dbcnt <= '0;
        end else begin
          dbcnt <= dbcnt + 1'b1;
        end
      end else begin
        dbcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      arrival <= 1'b0;
    end else begin
      arrival <= db & ~db_q;
    end
  end

  // Timer restarts after each full departure period, queue empty or not.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      dtmr <= '0;
    end else if (!green) begin
      dtmr <= '0;
    end else if (dtmr == DP_W'(DEPART_CYCLES - 1)) begin
      dtmr <= '0;
    end else begin
      dtmr <= dtmr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      car_count <= '0;
    end else begin
      unique case ({arrival, dep})
        2'b10:   if (!full) car_count <= car_count + 1'b1;
        2'b01:   car_count <= car_count - 1'b1;
        default: car_count <= car_count;
      endcase
    end
  end

`ifdef MIN_GREEN_HOLD_EN
  localparam int HG_W = $clog2(MIN_GREEN + 1);
  logic [HG_W-1:0] hcnt;
  logic            held;

  assign held = (hcnt < HG_W'(MIN_GREEN - 1));

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      hcnt <= '0;
    end else if (state != SERVE) begin
      hcnt <= '0;
    end else if (held) begin
      hcnt <= hcnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      wtmr  <= '0;
      X     <= 1'b0;
    end else begin
      state <= nxt;
      X     <= (nxt == REQ) || (nxt == SERVE);
      if (state == WAIT) begin
        wtmr <= wtmr + 1'b1;
      end else begin
        wtmr <= '0;
      end
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (over) begin
          nxt = REQ;
        end else if (!empty) begin
          nxt = WAIT;
        end
      end
      WAIT: begin
        if (empty) begin
          nxt = IDLE;
        end else if (over || wtmr == WT_W'(MAX_WAIT - 1)) begin
          nxt = REQ;
        end
      end
      REQ: begin
        if (empty) begin
          nxt = IDLE;
        end else if (green) begin
          nxt = SERVE;
        end
      end
      SERVE: begin
`ifdef MIN_GREEN_HOLD_EN
        if (empty && !held) begin
          nxt = IDLE;
        end else if (!green && !empty) begin
          nxt = REQ;
        end
`else
        if (empty) begin
          nxt = IDLE;
        end else if (!green) begin
          nxt = REQ;
        end
`endif
      end
      default: nxt = IDLE;
    endcase
  end

endmodule
